register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 8, is the data width of every register.
REQ-002 Port clk, input, 1, is the single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1, is the asynchronous active-low reset.
REQ-004 Port wr_en, input, 1, is the write strobe for the write port.
REQ-005 Port wr_addr, input, 4, is the write address in reg_addr_e encoding.
REQ-006 Port wr_data, input, DATA_W, is the write data.
REQ-007 Ports rd_a_addr and rd_b_addr, input, 4 each, are the read addresses in reg_addr_e encoding.
REQ-008 Ports rd_a_data and rd_b_data, output, DATA_W each, are the read data.
REQ-009 Port flag_we, input, 1, is the strobe for an ALU flag update.
REQ-010 Port flag_in, input, 4, carries the new flags, indexed by status_flag_e (0=Z, 1=N, 2=C, 3=V).
REQ-011 Port pc_inc, input, 1, requests an instruction-pointer increment.
REQ-012 Ports ibar_q and ioff_q, output, DATA_W each, mirror IBAR and IOFF continuously.
REQ-013 Port status_q, output, 4, mirrors STATUS[3:0] continuously.
REQ-014 Port illegal_addr, output, 1, is a one-cycle registered pulse when a write targets a reserved address.

Function
REQ-015 Storage: R0-R7, ACC, DBAR, DOFF, IBAR and IOFF are DATA_W-bit registers; STATUS holds 4 flag bits, and bits above 3 read as 0.
REQ-016 Reserved addresses 4'b1011 and 4'b1100:
- Reads return 0.
- Writes are ignored and assert illegal_addr on the following cycle.
REQ-017 Reads are combinational from current state, with zero latency (bypass behaviour per REQ-028).
REQ-018 Writes: when wr_en=1, the addressed register takes wr_data at the clock edge; read data reflects the new value from the next cycle.
REQ-019 Flag update: when flag_we=1, STATUS[3:0] takes flag_in at the clock edge.
REQ-020 STATUS collision: wr_en=1 with wr_addr=STATUS and flag_we=1 in the same cycle makes the explicit write win; flag_in is discarded.
REQ-021 pc_inc: {IBAR,IOFF} increments as a 2*DATA_W-bit value.
- IOFF wraps from all-ones to 0.
- IBAR increments by 1 on that wrap.
- IBAR wraps from all-ones to 0 silently.
REQ-022 pc_inc collision: a same-cycle explicit write to IOFF or IBAR wins for the written register.
- Written IOFF: the increment is dropped entirely, with no carry into IBAR.
- Written IBAR: IOFF still increments, and any carry is discarded.
REQ-023 Writes to R0 are stored normally; R0 is not hardwired to zero.
REQ-024 The two read ports are fully independent; both may address the same register.

Reset
REQ-025 On rst_n=0, all registers and STATUS clear to 0 asynchronously; illegal_addr clears to 0.
REQ-026 While rst_n=0, wr_en, flag_we and pc_inc are ignored.
REQ-027 Reset release: the first update occurs on the first rising clk edge with rst_n=1. A reset asserted mid-write leaves the target at 0.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN:
- Defined: a read whose address equals wr_addr while wr_en=1 (non-reserved address) returns wr_data in the same cycle. A read of STATUS while flag_we=1 and not overridden returns flag_in. Read of IOFF/IBAR is not bypassed for pc_inc.
- Undefined: reads always return the registered value (REQ-017, REQ-018).

Verification
REQ-029 Write R3=8'hA5, then read R3 on port A and R3 on port B next cycle -> both ports return 8'hA5; all other registers return 0.
REQ-030 IOFF=8'hFF, IBAR=8'h12, pulse pc_inc -> IOFF=8'h00, IBAR=8'h13. Repeat with IBAR=8'hFF -> IBAR=8'h00.
REQ-031 Same cycle: wr_en to STATUS with 8'h05, plus flag_we with flag_in=4'hA -> status_q=4'h5. Next cycle, flag_we only with 4'hA -> status_q=4'hA.
REQ-032 Write to 4'b1011 with 8'hFF -> illegal_addr high for exactly one cycle; reading 4'b1011 returns 0; no other register changes.
REQ-033 Same cycle: pc_inc plus write IOFF=8'h40 -> IOFF=8'h40 and IBAR unchanged. Then assert rst_n=0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
REQ-034 With REGFILE_BYPASS_EN: write ACC=8'h3C while reading ACC -> rd_a_data=8'h3C in the same cycle. Without the macro, the same cycle returns the old value 8'h00.

Source files
------------

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   Small CPU register file: R0-R7, ACC, DBAR, DOFF, IBAR, IOFF (DATA_W bits)
//   and a 4-bit STATUS flag register. One write port, two independent
//   combinational read ports, an ALU flag-update port and an instruction
//   pointer increment ({IBAR,IOFF} as one 2*DATA_W counter).
//
//   Address map (reg_addr_e):
//     0-7 R0-R7, 8 ACC, 9 DBAR, 10 DOFF, 11/12 reserved,
//     13 IBAR, 14 IOFF, 15 STATUS
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     wr_en/wr_addr/wr_data write port
//     rd_a_addr/rd_a_data   read port A (combinational)
//     rd_b_addr/rd_b_data   read port B (combinational)
//     flag_we/flag_in       STATUS flag update (Z,N,C,V = bits 0..3)
//     pc_inc                increment {IBAR,IOFF}
//     ibar_q/ioff_q         continuous mirrors of IBAR/IOFF
//     status_q              continuous mirror of STATUS[3:0]
//     illegal_addr          one-cycle pulse after a write to a reserved address
//
//   Optional feature (macro REGFILE_BYPASS_EN): same-cycle write data and
//   flag_in are forwarded to the read ports.
// -----------------------------------------------------------------------------
module register_file #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        rd_a_addr,
  input  logic [3:0]        rd_b_addr,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              flag_we,
  input  logic [3:0]        flag_in,
  input  logic              pc_inc,
  output logic [DATA_W-1:0] ibar_q,
  output logic [DATA_W-1:0] ioff_q,
  output logic [3:0]        status_q,
  output logic              illegal_addr
);

  typedef enum logic [3:0] {
    ADDR_R0 = 4'd0, ADDR_R1 = 4'd1, ADDR_R2 = 4'd2, ADDR_R3 = 4'd3,
    ADDR_R4 = 4'd4, ADDR_R5 = 4'd5, ADDR_R6 = 4'd6, ADDR_R7 = 4'd7,
    ADDR_ACC = 4'd8, ADDR_DBAR = 4'd9, ADDR_DOFF = 4'd10,
    ADDR_RSV0 = 4'd11, ADDR_RSV1 = 4'd12,
    ADDR_IBAR = 4'd13, ADDR_IOFF = 4'd14, ADDR_STATUS = 4'd15
  } reg_addr_e;

  typedef enum logic [1:0] {
    FLAG_Z = 2'd0, FLAG_N = 2'd1, FLAG_C = 2'd2, FLAG_V = 2'd3
  } status_flag_e;

  localparam int NUM_GPR = 11;  // R0-R7, ACC, DBAR, DOFF share addresses 0..10

  logic [DATA_W-1:0] gpr [0:NUM_GPR-1];
  logic [DATA_W-1:0] ibar;
  logic [DATA_W-1:0] ioff;
  logic [3:0]        status;

  logic              wr_rsv;
  logic              wr_ibar;
  logic              wr_ioff;
  logic              wr_status;
  logic              ioff_carry;
  logic [DATA_W-1:0] ioff_inc;
  logic [DATA_W-1:0] ibar_nxt;
  logic [DATA_W-1:0] ioff_nxt;
  logic [3:0]        status_nxt;

  assign wr_rsv    = wr_en && ((wr_addr == ADDR_RSV0) || (wr_addr == ADDR_RSV1));
  assign wr_ibar   = wr_en && (wr_addr == ADDR_IBAR);
  assign wr_ioff   = wr_en && (wr_addr == ADDR_IOFF);
  assign wr_status = wr_en && (wr_addr == ADDR_STATUS);

  assign {ioff_carry, ioff_inc} = {1'b0, ioff} + {{DATA_W{1'b0}}, 1'b1};

  // Instruction pointer and STATUS next-state. An explicit write always wins
  // for the register it targets. A written IOFF also suppresses the carry
  // into IBAR, because the increment it came from never happened.
  always_comb begin
    ibar_nxt   = ibar;
    ioff_nxt   = ioff;
    status_nxt = status;
    if (pc_inc) begin
      ioff_nxt = ioff_inc;
      if (ioff_carry && !wr_ioff) begin
        ibar_nxt = ibar + {{(DATA_W-1){1'b0}}, 1'b1};
      end
    end
    if (wr_ibar) ibar_nxt = wr_data;
    if (wr_ioff) ioff_nxt = wr_data;
    if (wr_status) begin
      status_nxt = wr_data[3:0];
    end else if (flag_we) begin
      status_nxt = flag_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
      ibar         <= '0;
      ioff         <= '0;
      status       <= '0;
      illegal_addr <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (wr_en && (wr_addr == 4'(i))) gpr[i] <= wr_data;
      end
      ibar         <= ibar_nxt;
      ioff         <= ioff_nxt;
      status       <= status_nxt;
      illegal_addr <= wr_rsv;
    end
  end

  function automatic logic [DATA_W-1:0] zext4(input logic [3:0] v);
    logic [DATA_W-1:0] r;
    r      = '0;
    r[3:0] = v;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] read_reg(input logic [3:0] addr);
    logic [DATA_W-1:0] d;
    d = '0;
    case (addr)
      ADDR_RSV0, ADDR_RSV1: d = '0;
      ADDR_IBAR:            d = ibar;
      ADDR_IOFF:            d = ioff;
      ADDR_STATUS:          d = zext4(status);
      default:              d = gpr[addr];
    endcase
`ifdef REGFILE_BYPASS_EN
    // Forward same-cycle updates. pc_inc is intentionally not forwarded.
    if (wr_en && !wr_rsv && (addr == wr_addr)) begin
      d = (addr == ADDR_STATUS) ? zext4(wr_data[3:0]) : wr_data;
    end else if ((addr == ADDR_STATUS) && flag_we) begin
      d = zext4(flag_in);
    end
`endif
    return d;
  endfunction

  always_comb begin
    rd_a_data = read_reg(rd_a_addr);
    rd_b_data = read_reg(rd_b_addr);
  end

  assign ibar_q   = ibar;
  assign ioff_q   = ioff;
  assign status_q = status;

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  localparam int W = 8;

  // Output selectors for scoreboard entries.
  localparam int S_RDA = 0, S_RDB = 1, S_IBAR = 2, S_IOFF = 3, S_STAT = 4, S_ILL = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [3:0]   rd_a_addr;
  logic [3:0]   rd_b_addr;
  logic [W-1:0] rd_a_data;
  logic [W-1:0] rd_b_data;
  logic         flag_we;
  logic [3:0]   flag_in;
  logic         pc_inc;
  logic [W-1:0] ibar_q;
  logic [W-1:0] ioff_q;
  logic [3:0]   status_q;
  logic         illegal_addr;

  register_file #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .flag_we(flag_we), .flag_in(flag_in), .pc_inc(pc_inc),
    .ibar_q(ibar_q), .ioff_q(ioff_q), .status_q(status_q),
    .illegal_addr(illegal_addr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           sel_q[$];
  string        name_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic expect_out(input int sel, input logic [W-1:0] val, input string name);
    sel_q.push_back(sel);
    exp_q.push_back(val);
    name_q.push_back(name);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (sel_q.size() > 0) begin
      int           s;
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        nm;
      s  = sel_q.pop_front();
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      case (s)
        S_RDA:   a = rd_a_data;
        S_RDB:   a = rd_b_data;
        S_IBAR:  a = ibar_q;
        S_IOFF:  a = ioff_q;
        S_STAT:  a = {4'b0, status_q};
        default: a = {7'b0, illegal_addr};
      endcase
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got %02h expected %02h", nm, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    flag_we = 1'b0;
    pc_inc  = 1'b0;
  endtask

  task automatic drive_wr(input logic [3:0] a, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [W-1:0] d);
    drive_wr(a, d);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_a_addr = '0; rd_b_addr = '0; flag_we = 1'b0; flag_in = '0; pc_inc = 1'b0;
    #2;
    // Strobes during reset are ignored.
    drive_wr(4'd0, 8'hFF);
    flag_we = 1'b1; flag_in = 4'hF; pc_inc = 1'b1;
    expect_out(S_RDA, 8'h00, "rst_r0");
    expect_out(S_IBAR, 8'h00, "rst_ibar");
    expect_out(S_IOFF, 8'h00, "rst_ioff");
    expect_out(S_STAT, 8'h00, "rst_status");
    expect_out(S_ILL, 8'h00, "rst_illegal");
    step();
    expect_out(S_RDA, 8'h00, "rst_r0_ignored_wr");
    expect_out(S_STAT, 8'h00, "rst_flag_ignored");
    expect_out(S_IOFF, 8'h00, "rst_pc_ignored");
    step();
    rst_n = 1'b1;
    step();

    // R3 = A5; same-cycle read depends on bypass.
    drive_wr(4'd3, 8'hA5);
    rd_a_addr = 4'd3;
    expect_out(S_RDA, BYP ? 8'hA5 : 8'h00, "r3_same_cycle");
    step();
    rd_a_addr = 4'd3; rd_b_addr = 4'd3;
    expect_out(S_RDA, 8'hA5, "r3_port_a");
    expect_out(S_RDB, 8'hA5, "r3_port_b");
    for (int i = 0; i < 16; i++) begin
      step();
      rd_a_addr = 4'(i);
      expect_out(S_RDA, (i == 3) ? 8'hA5 : 8'h00, $sformatf("scan_addr_%0d", i));
    end
    step();

    // R0 is a normal register.
    write_reg(4'd0, 8'h5A);
    rd_a_addr = 4'd0; rd_b_addr = 4'd3;
    expect_out(S_RDA, 8'h5A, "r0_stored");
    expect_out(S_RDB, 8'hA5, "r3_still");
    step();

    // IOFF wrap carries into IBAR.
    write_reg(4'd14, 8'hFF);
    write_reg(4'd13, 8'h12);
    pc_inc = 1'b1;
    step();
    expect_out(S_IOFF, 8'h00, "pc_wrap_ioff");
    expect_out(S_IBAR, 8'h13, "pc_wrap_ibar");
    pc_inc = 1'b1;
    step();
    expect_out(S_IOFF, 8'h01, "pc_plain_ioff");
    expect_out(S_IBAR, 8'h13, "pc_plain_ibar");
    rd_a_addr = 4'd14; rd_b_addr = 4'd13;
    expect_out(S_RDA, 8'h01, "pc_read_ioff");
    expect_out(S_RDB, 8'h13, "pc_read_ibar");
    step();
    // Full wrap of {IBAR,IOFF}.
    write_reg(4'd13, 8'hFF);
    write_reg(4'd14, 8'hFF);
    pc_inc = 1'b1;
    step();
    expect_out(S_IOFF, 8'h00, "pc_full_wrap_ioff");
    expect_out(S_IBAR, 8'h00, "pc_full_wrap_ibar");
    step();

    // IBAR write collides with a carrying pc_inc: IOFF still wraps, carry lost.
    write_reg(4'd14, 8'hFF);
    drive_wr(4'd13, 8'h20);
    pc_inc = 1'b1;
    step();
    expect_out(S_IBAR, 8'h20, "pc_ibar_write_wins");
    expect_out(S_IOFF, 8'h00, "pc_ibar_write_ioff_inc");
    step();

    // STATUS: explicit write beats flag update.
    drive_wr(4'd15, 8'h05);
    flag_we = 1'b1; flag_in = 4'hA;
    step();
    expect_out(S_STAT, 8'h05, "status_write_wins");
    rd_a_addr = 4'd15;
    expect_out(S_RDA, 8'h05, "status_read");
    flag_we = 1'b1; flag_in = 4'hA;
    step();
    expect_out(S_STAT, 8'h0A, "status_flag_only");
    // Flag update forwarding on the read port.
    rd_a_addr = 4'd15;
    flag_we = 1'b1; flag_in = 4'h6;
    expect_out(S_RDA, BYP ? 8'h06 : 8'h0A, "status_flag_same_cycle");
    step();
    expect_out(S_STAT, 8'h06, "status_flag_6");
    drive_wr(4'd15, 8'hF3);
    step();
    rd_a_addr = 4'd15;
    expect_out(S_STAT, 8'h03, "status_upper_dropped");
    expect_out(S_RDA, 8'h03, "status_read_upper_zero");
    step();

    // Reserved addresses.
    drive_wr(4'd11, 8'hFF);
    expect_out(S_ILL, 8'h00, "illegal_not_yet");
    step();
    rd_a_addr = 4'd11; rd_b_addr = 4'd3;
    expect_out(S_ILL, 8'h01, "illegal_pulse");
    expect_out(S_RDA, 8'h00, "rsv11_reads_zero");
    expect_out(S_RDB, 8'hA5, "rsv_no_side_effect_r3");
    expect_out(S_STAT, 8'h03, "rsv_no_side_effect_status");
    step();
    expect_out(S_ILL, 8'h00, "illegal_one_cycle");
    drive_wr(4'd12, 8'h77);
    step();
    rd_a_addr = 4'd12;
    expect_out(S_ILL, 8'h01, "illegal_pulse_12");
    expect_out(S_RDA, 8'h00, "rsv12_reads_zero");
    step();

    // ACC write with a same-cycle read.
    drive_wr(4'd8, 8'h3C);
    rd_a_addr = 4'd8;
    expect_out(S_RDA, BYP ? 8'h3C : 8'h00, "acc_same_cycle");
    step();
    rd_a_addr = 4'd8;
    expect_out(S_RDA, 8'h3C, "acc_next_cycle");
    step();

    // IOFF write collides with a would-carry pc_inc: no carry reaches IBAR.
    write_reg(4'd14, 8'hFF);
    drive_wr(4'd14, 8'h40);
    pc_inc = 1'b1;
    step();
    expect_out(S_IOFF, 8'h40, "pc_ioff_write_wins");
    expect_out(S_IBAR, 8'h20, "pc_ioff_write_no_carry");
    step();

    // Mid-cycle reset with a write in flight.
    drive_wr(4'd1, 8'h77);
    rd_a_addr = 4'd3; rd_b_addr = 4'd8;
    #1;
    rst_n = 1'b0;
    expect_out(S_RDA, 8'h00, "async_rst_r3");
    expect_out(S_RDB, 8'h00, "async_rst_acc");
    expect_out(S_IBAR, 8'h00, "async_rst_ibar");
    expect_out(S_IOFF, 8'h00, "async_rst_ioff");
    expect_out(S_STAT, 8'h00, "async_rst_status");
    expect_out(S_ILL, 8'h00, "async_rst_illegal");
    step();
    rst_n = 1'b1;
    step();
    rd_a_addr = 4'd1;
    expect_out(S_RDA, 8'h00, "rst_mid_write_target");
    step();
    step();

    // Drain with a bound.
    for (int k = 0; k < 20 && sel_q.size() > 0; k++) @(posedge clk);
    if (sel_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sel_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
